canright_inv_pipe: RTL

//  - Multi-lane, pipelined GF(2^4) inverter for the small-scale AES datapath; polynomial x^4+x+1.
//  - Uses the GF(4)-tower (Canright) decomposition.
//  - Adds valid/ready flow control, configurable pipeline cuts and LANES parallel nibbles.
//  - Sits between the state register and the mixing layer. Feeds the masked S-box wrapper.

---
 rtl/canright_inv_pipe.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/canright_inv_pipe.sv
// canright_inv_pipe: LANES-wide pipelined GF(2^4) inverter (x^4+x+1) using a GF(4) tower with valid/ready flow control.
// Define CANRIGHT_PIPE_AFFINE_EN to append the small-scale AES affine layer (constant 0x6) in the last stage.
module canright_inv_pipe #(
   parameter int LANES  = 4,
   parameter int STAGES = 2
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [4*LANES-1:0] in_data,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [4*LANES-1:0] out_data,
   output logic               busy
);
   localparam int DW = 4*LANES;
   localparam int MW = 6*LANES;  // per lane: tower nibble {g1,g0} in [5:2], GF(4) partial in [1:0]

   if (LANES < 1 || LANES > 16) begin : g_bad_lanes
      $error("canright_inv_pipe: LANES=%0d outside 1..16", LANES);
   end

   // GF(4) in polynomial basis {w,1}, w^2 = w + 1
   function automatic logic [1:0] gf4_mul(input logic [1:0] a, input logic [1:0] b);
      logic [1:0] r;
      r[1] = (a[1] & b[1]) ^ (a[1] & b[0]) ^ (a[0] & b[1]);
      r[0] = (a[1] & b[1]) ^ (a[0] & b[0]);
      return r;
   endfunction

   // N*a^2 with N = w reduces to swapping the two bits
   function automatic logic [1:0] gf4_sq_scale(input logic [1:0] a);
      return {a[0], a[1]};
   endfunction

   // a^-1 = a^2 for nonzero a; 0 maps to 0 for free
   function automatic logic [1:0] gf4_inv(input logic [1:0] a);
      return {a[1], a[1] ^ a[0]};
   endfunction

   // Tower normal basis over GF(4) is {Y, Y^4} with Y = x, so Y + Y^4 = 1 and Y*Y^4 = w.
   // Tower bits {t3,t2,t1,t0} weigh {wY, Y, wY^4, Y^4} = {0xC, 0x2, 0xA, 0x3}.
   function automatic logic [3:0] basis_in(input logic [3:0] s);
      return {s[2], s[0] ^ s[1] ^ s[2] ^ s[3], s[2] ^ s[3], s[0]};
   endfunction

   function automatic logic [3:0] basis_out(input logic [3:0] t);
      return {t[3] ^ t[1], t[3], t[2] ^ t[1] ^ t[0], t[0]};
   endfunction

`ifdef CANRIGHT_PIPE_AFFINE_EN
   function automatic logic [3:0] affine(input logic [3:0] x);
      return {x[0] ^ x[1] ^ x[3], ~(x[0] ^ x[2] ^ x[3]), ~(x[1] ^ x[2] ^ x[3]), x[0] ^ x[1] ^ x[2]};
   endfunction
`endif

   // Inverse of g1*Y + g0*Y^4 is d^-1 * (g0*Y + g1*Y^4): swap halves, scale both by d^-1
   function automatic logic [3:0] lane_back(input logic [5:0] m);
      logic [3:0] r;
      r = basis_out({gf4_mul(m[1:0], m[3:2]), gf4_mul(m[1:0], m[5:4])});
`ifdef CANRIGHT_PIPE_AFFINE_EN
      return affine(r);
`else
      return r;
`endif
   endfunction

   logic [MW-1:0]     f_out;
   logic [MW-1:0]     m_in;
   logic [MW-1:0]     m_out;
   logic [MW-1:0]     b_in;
   logic [DW-1:0]     b_out;
   logic [DW-1:0]     out_reg;
   logic [STAGES-1:0] vld;
   logic [STAGES-1:0] prev_v;
   logic [STAGES-1:0] load;

   genvar gi;
   for (gi = 0; gi < LANES; gi++) begin : g_lane
      logic [3:0] t;
      assign t = basis_in(in_data[4*gi +: 4]);
      assign f_out[6*gi +: 6] = {t, gf4_mul(t[3:2], t[1:0]) ^ gf4_sq_scale(t[3:2] ^ t[1:0])};
      assign m_out[6*gi +: 6] = {m_in[6*gi+2 +: 4], gf4_inv(m_in[6*gi +: 2])};
      assign b_out[4*gi +: 4] = lane_back(b_in[6*gi +: 6]);
   end

   // A stage may load when some stage at or after it is empty, or downstream takes the output.
   for (gi = 0; gi < STAGES; gi++) begin : g_load
      assign load[gi] = out_ready || !(&vld[STAGES-1:gi]);
   end

   assign prev_v = STAGES'({vld, in_valid});

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld <= '0;
      end else begin
         for (int k = 0; k < STAGES; k++) begin
            if (load[k]) vld[k] <= prev_v[k];
         end
      end
   end

   if (STAGES == 1) begin : g_s1
      assign m_in = f_out;
      assign b_in = m_out;
   end else if (STAGES == 2) begin : g_s2
      logic [MW-1:0] cut1_reg;
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n)                   cut1_reg <= '0;
         else if (load[0] && in_valid) cut1_reg <= m_out;
      end
      assign m_in = f_out;
      assign b_in = cut1_reg;
   end else if (STAGES == 3) begin : g_s3
      logic [MW-1:0] cut1_reg;
      logic [MW-1:0] cut2_reg;
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            cut1_reg <= '0;
            cut2_reg <= '0;
         end else begin
            if (load[0] && in_valid) cut1_reg <= f_out;
            if (load[1] && vld[0])   cut2_reg <= m_out;
         end
      end
      assign m_in = cut1_reg;
      assign b_in = cut2_reg;
   end else begin : g_bad_stages
      $error("canright_inv_pipe: STAGES=%0d outside 1..3", STAGES);
      assign m_in = f_out;
      assign b_in = m_out;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                                     out_reg <= '0;
      else if (load[STAGES-1] && prev_v[STAGES-1])    out_reg <= b_out;
   end

   assign in_ready  = load[0];
   assign out_valid = vld[STAGES-1];
   assign out_data  = out_reg;
   assign busy      = |vld;

endmodule
